// File: rtl/rr_arbiter_bin.sv
// Round-robin arbiter with a registered binary grant index and a
// valid/ready handshake. The pointer names the highest-priority requester;
// after an accepted grant it moves to the line just past the winner, so the
// winner drops to lowest priority. Indices wrap modulo NUM_REQ.
module rr_arbiter_bin #(
    parameter int NUM_REQ = 16,
    parameter int BIN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               gnt_ready_i,
    output logic               gnt_valid_o,
    output logic [BIN_W-1:0]   gnt_idx_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [BIN_W:0] N_EXT = (BIN_W+1)'(NUM_REQ);

    state_e           state_q, state_d;
    logic [BIN_W-1:0] ptr_q, ptr_d;
    logic [BIN_W-1:0] idx_q, idx_d;
    logic [BIN_W-1:0] ptr_inc;
    logic             any_req;

    // (a + b) mod NUM_REQ for a, b < NUM_REQ; one spare bit holds the carry
    function automatic logic [BIN_W-1:0] wrap_add(input logic [BIN_W-1:0] a,
                                                  input logic [BIN_W-1:0] b);
        logic [BIN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) s = s - N_EXT;
        return s[BIN_W-1:0];
    endfunction

    // Rotate so that bit 0 is the pointer position, take the lowest set bit,
    // then map the offset back to an absolute index. Relies on p < NUM_REQ.
    function automatic logic [BIN_W-1:0] pick(input logic [NUM_REQ-1:0] req,
                                              input logic [BIN_W-1:0]   p);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [BIN_W-1:0]     off;
        dbl = {req, req} >> p;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = BIN_W'(i);
        end
        return wrap_add(p, off);
    endfunction

    assign any_req = |req_i;
    assign ptr_inc = wrap_add(idx_q, BIN_W'(1));

    // Next-state: issue from IDLE, hold under backpressure, re-arbitrate on handshake
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = pick(req_i, ptr_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ready_i) begin
                    ptr_d = ptr_inc;
                    if (any_req) idx_d = pick(req_i, ptr_inc);
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and grant index registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_idx_o   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_bin.sv
// Bench for rr_arbiter_bin: a 16-line instance and a 5-line instance share
// clock and reset. A cycle-level behavioural model (integer arithmetic,
// modulo scan) predicts valid/index; directed phases add fixed expectations.
module tb_rr_arbiter_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_a;
    logic        rdy_a;
    logic        vld_a;
    logic [3:0]  idx_a;
    logic [4:0]  req_b;
    logic        rdy_b;
    logic        vld_b;
    logic [2:0]  idx_b;

    int total = 0;
    int bad   = 0;

    // model state: [0] = 16-line instance, [1] = 5-line instance
    bit m_vld [2];
    int m_idx [2];
    int m_ptr [2];
    bit m_rst_seen;

    rr_arbiter_bin #(.NUM_REQ(16), .BIN_W(4)) u_a (
        .clk(clk), .reset(rst), .req_i(req_a), .gnt_ready_i(rdy_a),
        .gnt_valid_o(vld_a), .gnt_idx_o(idx_a)
    );

    rr_arbiter_bin #(.NUM_REQ(5), .BIN_W(3)) u_b (
        .clk(clk), .reset(rst), .req_i(req_b), .gnt_ready_i(rdy_b),
        .gnt_valid_o(vld_b), .gnt_idx_o(idx_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // first requester found scanning p, p+1, ... modulo n
    function automatic int mpick(input int req, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (p + i) % n;
            if (((req >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input int u, input int n, input int req, input bit rdy);
        if (rst) begin
            m_vld[u] = 0; m_idx[u] = 0; m_ptr[u] = 0;
        end else if (!m_vld[u]) begin
            if (req != 0) begin
                m_idx[u] = mpick(req, m_ptr[u], n);
                m_vld[u] = 1;
            end
        end else if (rdy) begin
            m_ptr[u] = (m_idx[u] + 1) % n;
            if (req != 0) m_idx[u] = mpick(req, m_ptr[u], n);
            else          m_vld[u] = 0;
        end
    endtask

    // one clock: advance the model on the edge, compare #1 later
    task automatic tick();
        bit was_rst;
        @(posedge clk);
        was_rst = rst;
        model_step(0, 16, int'(req_a), rdy_a);
        model_step(1, 5, int'(req_b), rdy_b);
        #1;
        chk("a_vld", int'(vld_a), int'(m_vld[0]));
        if (m_vld[0] || was_rst) chk("a_idx", int'(idx_a), m_idx[0]);
        chk("b_vld", int'(vld_b), int'(m_vld[1]));
        if (m_vld[1] || was_rst) chk("b_idx", int'(idx_b), m_idx[1]);
        if (vld_b) chk("b_range", int'(idx_b < 3'd5), 1);
    endtask

    task automatic rand_b();
        req_b = 5'($urandom & $urandom);
        rdy_b = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1; req_a = 16'hFFFF; rdy_a = 1'b0; req_b = 5'h1F; rdy_b = 1'b0;
        m_vld = '{0, 0}; m_idx = '{0, 0}; m_ptr = '{0, 0};
        m_rst_seen = 0;

        // reset held with all requests pending
        repeat (2) begin
            tick();
            chk("rst_vld", int'(vld_a), 0);
            chk("rst_idx", int'(idx_a), 0);
        end

        // first grant after release is index 0
        rst = 1'b0;
        tick();
        chk("first_a", int'(idx_a), 0);
        chk("first_b", int'(idx_b), 0);

        // fair rotation, one grant per cycle
        rdy_a = 1'b1; rdy_b = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("rot_a_vld", int'(vld_a), 1);
            chk("rot_a", int'(idx_a), (i + 1) % 16);
            chk("rot_b", int'(idx_b), (i + 1) % 5);
        end

        // backpressure from a clean pointer
        rst = 1'b1; tick();
        rst = 1'b0; req_a = 16'h0000; rdy_a = 1'b0; rand_b(); tick();
        req_a = 16'h0210;
        for (int i = 0; i < 5; i++) begin
            rand_b(); tick();
            chk("bp_hold", int'(idx_a), 4);
        end
        req_a = 16'h0000; rand_b(); tick();
        chk("bp_drop", int'(idx_a), 4);
        chk("bp_drop_vld", int'(vld_a), 1);
        rdy_a = 1'b1; rand_b(); tick();
        chk("bp_idle", int'(vld_a), 0);
        rdy_a = 1'b0; req_a = 16'h0210; rand_b(); tick();
        chk("bp_next", int'(idx_a), 9);

        // wrap-around and lowest priority for the winner
        rdy_a = 1'b1; req_a = 16'h4000; rand_b(); tick();
        chk("wrap_14", int'(idx_a), 14);
        req_a = 16'h8008;
        rand_b(); tick(); chk("wrap_15", int'(idx_a), 15);
        rand_b(); tick(); chk("wrap_3", int'(idx_a), 3);
        rand_b(); tick(); chk("wrap_15b", int'(idx_a), 15);
        req_a = 16'h0001;
        rand_b(); tick(); chk("sole_0", int'(idx_a), 0);
        rand_b(); tick(); chk("sole_0b", int'(idx_a), 0);
        chk("sole_vld", int'(vld_a), 1);

        // reset while a grant is pending under backpressure
        req_a = 16'h0080; rand_b(); tick();
        chk("mid_7", int'(idx_a), 7);
        rdy_a = 1'b0; rand_b(); tick();
        chk("mid_hold", int'(idx_a), 7);
        rst = 1'b1; rand_b(); tick();
        chk("mid_rst_vld", int'(vld_a), 0);
        rst = 1'b0; req_a = 16'hFFFF; rand_b(); tick();
        chk("mid_restart", int'(idx_a), 0);

        // randomized traffic, including rare resets
        for (int i = 0; i < 600; i++) begin
            req_a = 16'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) req_a = 16'h0000;
            rdy_a = ($urandom_range(0, 2) != 0);
            rand_b();
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
